// File: rtl/core_ifetch_if.sv
// Instruction-memory read channel: address request and read data, each with valid/ready.
interface core_ifetch_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata
  );
endinterface

// File: rtl/core_ifetch.sv
// RV32I instruction fetch: PC, single-outstanding imem read, IF/ID register with stall and flush/redirect.
module core_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic [31:0]   REDIRECT_PC,
  core_ifetch_if.master imem,
  output logic [31:0]   INSTRUCTION,
  output logic [31:0]   ID_PC,
  output logic          ID_VALID
);

  typedef enum logic [1:0] {
    S_RESET,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] araddr, araddr_n;
  logic        drop, drop_n;
  logic [31:0] instr_n, id_pc_n;
  logic        id_valid_n;
  logic        rready, a_fire, r_fire, capture;

  always_comb begin
    rready  = (state == S_DATA) && (drop || FLUSH || !STALL);
    a_fire  = (state == S_ADDR) && imem.arready;
    r_fire  = rready && imem.rvalid;
    capture = r_fire && !drop && !FLUSH;
  end

  assign imem.arvalid = (state == S_ADDR);
  assign imem.araddr  = araddr;
  assign imem.rready  = rready;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    araddr_n   = araddr;
    drop_n     = drop;
    instr_n    = INSTRUCTION;
    id_pc_n    = ID_PC;
    id_valid_n = ID_VALID;

    if (FLUSH) pc_n = REDIRECT_PC & ALIGN_MASK;

    unique case (state)
      S_RESET: begin
        state_n  = S_ADDR;
        araddr_n = pc_n;
      end
      S_ADDR: begin
        // The address already on the bus stays put; its eventual response is discarded.
        if (FLUSH) drop_n = 1'b1;
        if (a_fire) state_n = S_DATA;
      end
      S_DATA: begin
        if (r_fire) begin
          if (capture) begin
            instr_n    = imem.rdata;
            id_pc_n    = araddr;
            id_valid_n = 1'b1;
            pc_n       = araddr + 32'd4;
          end else begin
            drop_n = 1'b0;
          end
          state_n  = S_ADDR;
          araddr_n = pc_n;
        end else if (FLUSH) begin
          drop_n = 1'b1;
        end
      end
      default: state_n = S_RESET;
    endcase

    if (FLUSH) begin
      id_valid_n = 1'b0;
      instr_n    = NOP_INSTR;
    end else if (!STALL && !capture) begin
      id_valid_n = 1'b0;
      instr_n    = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state       <= S_RESET;
      pc          <= RESET_PC & ALIGN_MASK;
      araddr      <= RESET_PC & ALIGN_MASK;
      drop        <= 1'b0;
      INSTRUCTION <= NOP_INSTR;
      ID_PC       <= '0;
      ID_VALID    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      araddr      <= araddr_n;
      drop        <= drop_n;
      INSTRUCTION <= instr_n;
      ID_PC       <= id_pc_n;
      ID_VALID    <= id_valid_n;
    end
  end

endmodule

// File: tb/tb_core_ifetch.sv
// Directed bench for core_ifetch: credit-gated memory model, delivery scoreboard, immediate assertions.
module tb_core_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] id_pc;
  logic        id_valid;

  int total;
  int bad;
  int ndeliv;
  int credit;
  int rlat;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  core_ifetch_if imem_bus ();

  assign imem_bus.arready = (credit > 0);

  core_ifetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .CLK        (clk),
    .NRST       (nrst),
    .STALL      (stall),
    .FLUSH      (flush),
    .REDIRECT_PC(redirect_pc),
    .imem       (imem_bus),
    .INSTRUCTION(instruction),
    .ID_PC      (id_pc),
    .ID_VALID   (id_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h1234_5673;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_deliv(input int n);
    for (int i = 0; i < 200 && ndeliv < n; i++) @(negedge clk);
    total++;
    assert (ndeliv >= n) else begin
      bad++;
      $error("FAIL wait_deliv observed=%0d expected=%0d", ndeliv, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_arvalid"}, imem_bus.arvalid, 1'b0);
    chk1({tag, "_rready"}, imem_bus.rready, 1'b0);
    chk({tag, "_araddr"}, imem_bus.araddr, 32'h0);
    chk({tag, "_instr"}, instruction, NOP);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk1({tag, "_id_valid"}, id_valid, 1'b0);
  endtask

  // Memory: ARREADY while credit remains, RVALID rlat cycles after the address handshake.
  initial begin
    bit          a_hs, r_hs, pend;
    logic [31:0] a_addr, p_addr;
    int          cnt;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    pend   = 1'b0;
    cnt    = 0;
    p_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      a_hs   = imem_bus.arvalid && imem_bus.arready;
      r_hs   = imem_bus.rvalid && imem_bus.rready;
      a_addr = imem_bus.araddr;
      @(posedge clk);
      #1;
      if (!nrst) begin
        pend            = 1'b0;
        imem_bus.rvalid = 1'b0;
      end else begin
        if (r_hs) begin
          imem_bus.rvalid = 1'b0;
          pend            = 1'b0;
        end
        if (a_hs) begin
          credit--;
          pend   = 1'b1;
          p_addr = a_addr;
          cnt    = rlat - 1;
        end else if (pend && !imem_bus.rvalid && cnt > 0) begin
          cnt--;
        end
        if (pend && !imem_bus.rvalid && cnt == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(p_addr);
        end
      end
    end
  end

  // Delivery monitor: a new IF/ID entry is popped against the scoreboard.
  initial begin
    logic        pv;
    logic [31:0] ppc, pin;
    exp_t        e;
    pv  = 1'b0;
    ppc = '0;
    pin = '0;
    forever begin
      @(posedge clk);
      #1;
      if (id_valid && (!pv || id_pc != ppc || instruction != pin)) begin
        ndeliv++;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_delivery observed pc=%h expected none", id_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_id_pc", id_pc, e.pc);
          chk("sb_instr", instruction, e.ins);
        end
      end
      pv  = id_valid;
      ppc = id_pc;
      pin = instruction;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst        = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = '0;
    credit      = 0;
    rlat        = 1;
    total       = 0;
    bad         = 0;
    ndeliv      = 0;

    // Reset and first zero-wait fetch
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    push(32'h0);
    credit = 1;
    nrst   = 1'b1;
    nxt();
    chk1("t1_arvalid", imem_bus.arvalid, 1'b1);
    chk("t1_araddr0", imem_bus.araddr, 32'h0);
    chk1("t1_idv_empty", id_valid, 1'b0);
    nxt();
    chk1("t1_rready", imem_bus.rready, 1'b1);
    chk1("t1_arvalid_data", imem_bus.arvalid, 1'b0);
    nxt();
    chk("t1_instr", instruction, 32'h0050_0093);
    chk("t1_id_pc", id_pc, 32'h0);
    chk1("t1_id_valid", id_valid, 1'b1);
    chk("t1_araddr4", imem_bus.araddr, 32'h4);
    wait_deliv(1);

    // Three-cycle read latency at 0x4
    rlat   = 3;
    credit += 1;
    push(32'h4);
    nxt();
    for (int i = 0; i < 3; i++) begin
      chk("t2_araddr_hold", imem_bus.araddr, 32'h4);
      chk1("t2_arvalid", imem_bus.arvalid, 1'b0);
      chk1("t2_bubble_valid", id_valid, 1'b0);
      chk("t2_bubble_instr", instruction, NOP);
      nxt();
    end
    wait_deliv(2);
    chk1("t2_id_valid", id_valid, 1'b1);
    chk("t2_instr", instruction, mem_word(32'h4));
    chk("t2_araddr8", imem_bus.araddr, 32'h8);

    // Stall for four cycles with the 0x8 response pending
    stall  = 1'b1;
    rlat   = 1;
    credit += 1;
    push(32'h8);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk1("t3_rready", imem_bus.rready, 1'b0);
      chk("t3_instr_hold", instruction, mem_word(32'h4));
      chk("t3_id_pc_hold", id_pc, 32'h4);
      chk1("t3_valid_hold", id_valid, 1'b1);
    end
    stall = 1'b0;
    wait_deliv(3);

    // Flush in the response cycle of 0xC, redirect to 0x103
    rlat   = 3;
    credit += 2;
    push(32'h100);
    nxt();
    nxt();
    nxt();
    chk("t4_araddr_c", imem_bus.araddr, 32'hC);
    chk1("t4_rready", imem_bus.rready, 1'b1);
    flush       = 1'b1;
    redirect_pc = 32'h0000_0103;
    nxt();
    chk("t4_araddr_redir", imem_bus.araddr, 32'h100);
    chk1("t4_arvalid", imem_bus.arvalid, 1'b1);
    chk1("t4_id_valid", id_valid, 1'b0);
    chk("t4_instr", instruction, NOP);
    flush = 1'b0;
    wait_deliv(4);

    // Flush while the address phase at 0x104 is blocked
    chk1("t5_arvalid", imem_bus.arvalid, 1'b1);
    chk("t5_araddr", imem_bus.araddr, 32'h104);
    flush       = 1'b1;
    redirect_pc = 32'h0000_0040;
    rlat        = 1;
    push(32'h40);
    nxt();
    chk("t5_araddr_hold1", imem_bus.araddr, 32'h104);
    chk1("t5_arvalid_hold", imem_bus.arvalid, 1'b1);
    chk1("t5_id_valid", id_valid, 1'b0);
    flush = 1'b0;
    nxt();
    chk("t5_araddr_hold2", imem_bus.araddr, 32'h104);
    credit += 2;
    stall  = 1'b1;
    nxt();
    chk1("t5_rready_drop", imem_bus.rready, 1'b1);
    chk1("t5_arvalid_data", imem_bus.arvalid, 1'b0);
    stall = 1'b0;
    nxt();
    chk("t5_araddr_redir", imem_bus.araddr, 32'h40);
    chk1("t5_arvalid2", imem_bus.arvalid, 1'b1);
    chk1("t5_id_valid2", id_valid, 1'b0);
    wait_deliv(5);

    // Unaligned redirect to the top word and wrap to zero
    chk("t6_araddr44", imem_bus.araddr, 32'h44);
    flush       = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    credit      += 2;
    push(32'hFFFF_FFFC);
    nxt();
    flush = 1'b0;
    wait_deliv(6);
    chk("t6_araddr_wrap", imem_bus.araddr, 32'h0);
    chk1("t6_arvalid", imem_bus.arvalid, 1'b1);
    chk("t6_id_pc", id_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of S_DATA
    stall  = 1'b1;
    credit += 1;
    rlat   = 3;
    nxt();
    chk1("t7_arvalid_data", imem_bus.arvalid, 1'b0);
    chk1("t7_id_valid", id_valid, 1'b1);
    chk("t7_id_pc", id_pc, 32'hFFFF_FFFC);
    #3;
    nrst = 1'b0;
    #1;
    chk_reset_outputs("t7_async");
    nxt();
    nxt();
    chk1("t7_rready_rst", imem_bus.rready, 1'b0);
    chk1("t7_arvalid_rst", imem_bus.arvalid, 1'b0);
    stall = 1'b0;
    nrst  = 1'b1;
    nxt();
    chk1("t7_arvalid_rel", imem_bus.arvalid, 1'b1);
    chk("t7_araddr_rel", imem_bus.araddr, 32'h0);
    nxt();
    nxt();
    chk("t7_araddr_wait", imem_bus.araddr, 32'h0);
    chk1("t7_id_valid_rel", id_valid, 1'b0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    chk("deliveries", ndeliv, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
